// File: rtl/divisor_serial_pkg.sv
// Shared definitions for the serial restoring divider: FSM state encoding
// and the default operand width. The optional zero-divisor flag is enabled
// with the DIV_BY_ZERO_EN macro.
package divisor_serial_pkg;

  // Default operand width for the divider
  localparam int DIV_WIDTH = 4;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divisor_serial_div_paso.sv
// Single restoring-division step (purely combinational). The caller has
// already shifted the next dividend bit into rem_i. This step subtracts the
// divisor magnitude when it fits and reports the quotient bit.
module div_paso #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // One extra bit so the borrow shows up as the sign of the trial difference
  logic [WIDTH:0] diff;

  // Trial subtract; keep the difference when non-negative, otherwise restore
  always_comb begin
    diff   = {1'b0, rem_i} - {1'b0, div_i};
    qbit_o = ~diff[WIDTH];
    rem_o  = qbit_o ? diff[WIDTH-1:0] : rem_i;
  end

endmodule

// File: rtl/divisor_serial.sv
// Multi-cycle signed divider, one quotient bit per clock, valid/ready on
// both sides. Operates on magnitudes and applies signs when the result is
// produced. Quotient is WIDTH+1 bits so that -2^(W-1) / -1 does not wrap.
// Define DIV_BY_ZERO_EN to short-circuit b==0 and expose the div_by_zero flag.
module divisor_serial
  import divisor_serial_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   q,
`ifdef DIV_BY_ZERO_EN
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
`else
  output logic [WIDTH-1:0] r
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;  // |a|, shifted out MSB first
  logic [WIDTH-1:0] divisor_q, divisor_d;    // |b|
  logic [WIDTH-1:0] rem_q, rem_d;            // partial remainder magnitude
  logic [WIDTH-1:0] quot_q, quot_d;          // quotient magnitude, built LSB-in
  logic [CW-1:0]    count_q, count_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH:0]   q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
`ifdef DIV_BY_ZERO_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH-1:0] step_rem_in, step_rem_out, quot_full;
  logic             step_qbit;

  // Bring the next dividend bit into the partial remainder. The remainder is
  // always below 2^(W-1) before the shift, so its top bit can be dropped.
  assign step_rem_in = {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
  assign quot_full   = {quot_q[WIDTH-2:0], step_qbit};

  div_paso #(.WIDTH(WIDTH)) u_paso (
    .rem_i  (step_rem_in),
    .div_i  (divisor_q),
    .rem_o  (step_rem_out),
    .qbit_o (step_qbit)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign q         = q_q;
  assign r         = r_q;
`ifdef DIV_BY_ZERO_EN
  assign div_by_zero = dbz_q;
`endif

  // Next-state and datapath update; everything holds unless a branch changes it
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    count_d    = count_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    q_d        = q_q;
    r_d        = r_q;
`ifdef DIV_BY_ZERO_EN
    dbz_d      = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          // |-2^(W-1)| still fits when read back as unsigned
          dividend_d = a[WIDTH-1] ? -a : a;
          divisor_d  = b[WIDTH-1] ? -b : b;
          sign_a_d   = a[WIDTH-1];
          sign_b_d   = b[WIDTH-1];
          rem_d      = '0;
          quot_d     = '0;
          count_d    = '0;
          state_d    = ST_CALC;
`ifdef DIV_BY_ZERO_EN
          if (b == '0) begin
            q_d     = '0;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        rem_d      = step_rem_out;
        quot_d     = quot_full;
        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
        count_d    = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          // Sign fix-up: quotient by sign(a)^sign(b), remainder by sign(a)
          q_d     = (sign_a_q ^ sign_b_q) ? -{1'b0, quot_full} : {1'b0, quot_full};
          r_d     = sign_a_q ? -step_rem_out : step_rem_out;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef DIV_BY_ZERO_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      count_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
`ifdef DIV_BY_ZERO_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      count_q    <= count_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      q_q        <= q_d;
      r_q        <= r_d;
`ifdef DIV_BY_ZERO_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

endmodule

// File: tb/tb_divisor_serial.sv
// Bench for divisor_serial (WIDTH=4): directed cases, backpressure, reset
// abort and random operands against an integer-arithmetic reference.
module tb_divisor_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   q;
  logic [W-1:0] r;
`ifdef DIV_BY_ZERO_EN
  logic         div_by_zero;
`endif

  int total = 0;
  int bad   = 0;

  divisor_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
`ifdef DIV_BY_ZERO_EN
    .r           (r),
    .div_by_zero (div_by_zero)
`else
    .r           (r)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: signed truncating division, remainder takes the dividend sign
  task automatic model(input int av, input int bv, output int eq, output int er,
                       output int ez, output int elat);
    ez   = 0;
    elat = W + 1;
    if (bv == 0) begin
`ifdef DIV_BY_ZERO_EN
      eq   = 0;
      ez   = 1;
      elat = 1;
`else
      eq = (av < 0) ? -((1 << W) - 1) : ((1 << W) - 1);
`endif
      er = av;
    end else begin
      eq = av / bv;
      er = av % bv;
    end
  endtask

  // Issue one operation, check latency, result and the return to idle.
  // hold > 0 keeps out_ready low for that many cycles once out_valid is up.
  task automatic run_op(input int av, input int bv, input int hold);
    int eq, er, ez, elat, lat, i;
    int q_m, r_m, q_s, r_s;
    model(av, bv, eq, er, ez, elat);
    q_m = eq & ((1 << (W + 1)) - 1);
    r_m = er & ((1 << W) - 1);
    i = 0;
    while (!in_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("ready_before_op", int'(in_ready), 1);
    a         = av[W-1:0];
    b         = bv[W-1:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    lat = 0;
    i   = 1;
    while (lat == 0 && i <= 40) begin
      if (out_valid) lat = i;
      else begin
        chk("busy_in_ready", int'(in_ready), 0);
        @(negedge clk);
        i++;
      end
    end
    chk("latency", lat, elat);
    if (lat == 0) return;
    chk("q", int'(q), q_m);
    chk("r", int'(r), r_m);
`ifdef DIV_BY_ZERO_EN
    chk("div_by_zero", int'(div_by_zero), ez);
`endif
    q_s = int'(q);
    r_s = int'(r);
    $display("op a=%0d b=%0d -> q=%0d r=%0d (ref q=%0d r=%0d) lat=%0d hold=%0d",
             av, bv, $signed(q), $signed(r), eq, er, lat, hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_q", int'(q), q_s);
      chk("hold_r", int'(r), r_s);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
`ifdef DIV_BY_ZERO_EN
    chk("post_dbz", int'(div_by_zero), 0);
`endif
  endtask

  initial begin
    int av, bv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    // Reset state while rst is still high
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", int'(in_ready), 1);

    // Directed cases
    run_op(7, 2, 0);
    run_op(-7, 2, 0);
    run_op(7, -2, 0);
    run_op(-8, -1, 0);
    run_op(-8, 1, 0);
    run_op(7, 0, 0);
    run_op(-8, 0, 0);
    run_op(-1, 7, 0);

    // Backpressure: result held six cycles
    run_op(5, 2, 6);

    // Reset on the second CALC cycle aborts the operation
    a        = 4'd5;
    b        = 4'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid_in_rst", int'(out_valid), 0);
    chk("abort_ready_in_rst", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", int'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_valid", int'(out_valid), 0);
      @(negedge clk);
    end
    run_op(6, 3, 0);

    // Random operands across the full signed range, b==0 included
    for (int n = 0; n < 30; n++) begin
      av = int'($urandom_range(15, 0)) - 8;
      bv = int'($urandom_range(15, 0)) - 8;
      run_op(av, bv, int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
